// File: rtl/grey_1000_display.sv
// Three-digit Johnson-code decade display driver.
// Resynchronises the ripple-clocked digit codes, filters inter-digit skew,
// decodes each digit and scans a common-bus seven-segment display.
module grey_1000_display #(
    parameter int unsigned SCAN_DIV = 1024,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [4:0] i_100,
    input  logic [4:0] i_010,
    input  logic [4:0] i_001,
    output logic [6:0] o_seg,
    output logic [2:0] o_dig,
    output logic       o_err
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {
        DIG_U = 2'd0,
        DIG_T = 2'd1,
        DIG_H = 2'd2
    } dig_t;

    logic [14:0]      r_s1, r_s2, r_s3, r_hold;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    dig_t             r_idx, w_idx_nxt;
    logic [6:0]       r_seg, w_seg_cur;
    logic [2:0]       r_dig, w_dig_cur;
    logic             r_err;
    logic [4:0]       w_h, w_t, w_u;
    logic             w_blank_h, w_blank_t, w_err;

    // {invalid, value}: only the ten Johnson codes are legal
    function automatic logic [4:0] f_dec(input logic [4:0] c);
        case (c)
            5'b00000: f_dec = 5'd0;
            5'b00001: f_dec = 5'd1;
            5'b00011: f_dec = 5'd2;
            5'b00111: f_dec = 5'd3;
            5'b01111: f_dec = 5'd4;
            5'b11111: f_dec = 5'd5;
            5'b11110: f_dec = 5'd6;
            5'b11100: f_dec = 5'd7;
            5'b11000: f_dec = 5'd8;
            5'b10000: f_dec = 5'd9;
            default:  f_dec = 5'b1_0000;
        endcase
    endfunction

    // Segment pattern {g,f,e,d,c,b,a}; invalid shows 'E'
    function automatic logic [6:0] f_seg(input logic [4:0] d);
        if (d[4]) begin
            f_seg = 7'h79;
        end else begin
            case (d[3:0])
                4'd0:    f_seg = 7'h3F;
                4'd1:    f_seg = 7'h06;
                4'd2:    f_seg = 7'h5B;
                4'd3:    f_seg = 7'h4F;
                4'd4:    f_seg = 7'h66;
                4'd5:    f_seg = 7'h6D;
                4'd6:    f_seg = 7'h7D;
                4'd7:    f_seg = 7'h07;
                4'd8:    f_seg = 7'h7F;
                default: f_seg = 7'h6F;
            endcase
        end
    endfunction

    // Two-flop synchroniser plus compare copy; hold only accepts a word seen
    // identically on two consecutive cycles, so one-cycle ripple never lands
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_s3   <= '0;
            r_hold <= '0;
        end else begin
            r_s1 <= {i_100, i_010, i_001};
            r_s2 <= r_s1;
            r_s3 <= r_s2;
            if (r_s2 == r_s3) begin
                r_hold <= r_s2;
            end
        end
    end

    // Decode held digits and work out leading-zero blanking
    always_comb begin
        w_h       = f_dec(r_hold[14:10]);
        w_t       = f_dec(r_hold[9:5]);
        w_u       = f_dec(r_hold[4:0]);
        w_blank_h = BLANK_LZ && !w_h[4] && (w_h[3:0] == 4'd0);
        w_blank_t = w_blank_h && !w_t[4] && (w_t[3:0] == 4'd0);
        w_err     = w_h[4] | w_t[4] | w_u[4];
    end

    // Scan state register: dwell counter and selected digit
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_cnt <= '0;
            r_idx <= DIG_U;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_idx <= w_idx_nxt;
        end
    end

    // Next scan state and the enable/pattern for the currently selected digit
    always_comb begin
        w_cnt_nxt = r_cnt + 1'b1;
        w_idx_nxt = r_idx;
        w_dig_cur = 3'b001;
        w_seg_cur = f_seg(w_u);
        if (r_cnt == CNT_W'(SCAN_DIV - 1)) begin
            w_cnt_nxt = '0;
            case (r_idx)
                DIG_U:   w_idx_nxt = DIG_T;
                DIG_T:   w_idx_nxt = DIG_H;
                default: w_idx_nxt = DIG_U;
            endcase
        end
        case (r_idx)
            DIG_T: begin
                w_dig_cur = 3'b010;
                w_seg_cur = w_blank_t ? 7'h00 : f_seg(w_t);
            end
            DIG_H: begin
                w_dig_cur = 3'b100;
                w_seg_cur = w_blank_h ? 7'h00 : f_seg(w_h);
            end
            default: ;
        endcase
    end

    // Output registers; digit enable and segments taken from the same index
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_seg <= '0;
            r_dig <= '0;
            r_err <= 1'b0;
        end else begin
            r_seg <= w_seg_cur;
            r_dig <= w_dig_cur;
            r_err <= w_err;
        end
    end

    assign o_seg = r_seg;
    assign o_dig = r_dig;
    assign o_err = r_err;

endmodule

// File: tb/tb_grey_1000_display.sv
// Directed bench for grey_1000_display with SCAN_DIV=4, blanking on and off.
module tb_grey_1000_display;

    logic       clk;
    logic       rst_n;
    logic [4:0] i_100, i_010, i_001;
    logic [6:0] seg, seg_nb;
    logic [2:0] dig, dig_nb;
    logic       err, err_nb;

    int unsigned n_vec;
    int unsigned n_err;

    grey_1000_display #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut (
        .i_clk(clk), .i_rst(rst_n), .i_100(i_100), .i_010(i_010), .i_001(i_001),
        .o_seg(seg), .o_dig(dig), .o_err(err)
    );

    grey_1000_display #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut_nb (
        .i_clk(clk), .i_rst(rst_n), .i_100(i_100), .i_010(i_010), .i_001(i_001),
        .o_seg(seg_nb), .o_dig(dig_nb), .o_err(err_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a digit to be selected, then check both instances
    task automatic chk_dig(input string tag, input logic [2:0] d,
                           input logic [6:0] exp, input logic [6:0] exp_nb);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (dig === d) found = 1'b1;
        end
        if (!found) begin
            n_vec++;
            n_err++;
            $error("FAIL %s: digit %b never selected, observed %b", tag, d, dig);
        end else begin
            chk({tag, "_seg"}, {1'b0, seg}, {1'b0, exp});
            chk({tag, "_nbseg"}, {1'b0, seg_nb}, {1'b0, exp_nb});
            chk({tag, "_nbdig"}, {5'b0, dig_nb}, {5'b0, d});
        end
    endtask

    // Bounded wait for the first output edge of a fresh dwell on digit d
    task automatic wait_dig_start(input logic [2:0] d);
        logic [2:0] prev;
        bit found;
        found = 1'b0;
        prev  = dig;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (dig === d && prev !== d) found = 1'b1;
            prev = dig;
        end
        if (!found) begin
            n_vec++;
            n_err++;
            $error("FAIL dwell_start: digit %b never entered, observed %b", d, dig);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [4:0] codes [11];
    logic [6:0] pats  [11];
    logic [2:0] exp_d;

    initial begin
        n_vec = 0;
        n_err = 0;
        codes = '{5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111,
                  5'b11110, 5'b11100, 5'b11000, 5'b10000, 5'b00000};
        pats  = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                  7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h3F};
        rst_n = 1'b0;
        i_100 = 5'b00000;
        i_010 = 5'b00000;
        i_001 = 5'b00000;

        // Reset state
        #1;
        chk("rst_seg", {1'b0, seg}, 8'h00);
        chk("rst_dig", {5'b0, dig}, 8'h00);
        chk("rst_err", {7'b0, err}, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Scan order and dwell, all digits zero
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            exp_d = 3'b001 << ((k / 4) % 3);
            chk("scan_dig", {5'b0, dig}, {5'b0, exp_d});
            chk("scan_seg", {1'b0, seg}, (exp_d == 3'b001) ? 8'h3F : 8'h00);
            chk("scan_nbseg", {1'b0, seg_nb}, 8'h3F);
            chk("scan_err", {7'b0, err}, 8'h00);
        end

        // 042: leading zero blanked only with blanking enabled
        @(posedge clk); #1;
        i_010 = 5'b01111;
        i_001 = 5'b00011;
        repeat (8) @(negedge clk);
        chk_dig("v042_u", 3'b001, 7'h5B, 7'h5B);
        chk_dig("v042_t", 3'b010, 7'h66, 7'h66);
        chk_dig("v042_h", 3'b100, 7'h00, 7'h3F);

        // One-cycle glitch on units never reaches the display
        @(posedge clk); #1;
        i_001 = 5'b00111;
        @(posedge clk); #1;
        i_001 = 5'b00011;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (dig === 3'b001) chk("glitch_seg", {1'b0, seg}, 8'h5B);
        end

        // Three-cycle pulse: old pattern after edge n+4, new after edge n+5
        wait_dig_start(3'b001);
        repeat (9) @(posedge clk);
        #1;
        i_001 = 5'b00111;
        repeat (3) @(posedge clk);
        #1;
        i_001 = 5'b00011;
        @(posedge clk);
        @(negedge clk);
        chk("lat_n4_dig", {5'b0, dig}, 8'h01);
        chk("lat_n4_seg", {1'b0, seg}, 8'h5B);
        @(negedge clk);
        chk("lat_n5_dig", {5'b0, dig}, 8'h01);
        chk("lat_n5_seg", {1'b0, seg}, 8'h4F);
        repeat (8) @(negedge clk);

        // Invalid hundreds: error flag after 5 edges, 'E' shown, tens unblanked
        i_010 = 5'b00000;
        repeat (8) @(negedge clk);
        @(posedge clk); #1;
        i_100 = 5'b10101;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("err_n4", {7'b0, err}, 8'h00);
        @(negedge clk);
        chk("err_n5", {7'b0, err}, 8'h01);
        chk("err_nb", {7'b0, err_nb}, 8'h01);
        chk_dig("inv_h", 3'b100, 7'h79, 7'h79);
        chk_dig("inv_t", 3'b010, 7'h3F, 7'h3F);
        chk_dig("inv_u", 3'b001, 7'h5B, 7'h5B);
        i_100 = 5'b00000;
        repeat (6) @(negedge clk);
        chk("err_clr", {7'b0, err}, 8'h00);
        chk_dig("clr_t", 3'b010, 7'h00, 7'h3F);

        // Units through the full Johnson sequence and back to zero
        for (int k = 0; k < 11; k++) begin
            i_001 = codes[k];
            repeat (6) @(negedge clk);
            chk_dig("step_u", 3'b001, pats[k], pats[k]);
        end

        // Reset mid-digit: index 2, counter 2
        wait_dig_start(3'b100);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mrst_seg", {1'b0, seg}, 8'h00);
        chk("mrst_dig", {5'b0, dig}, 8'h00);
        chk("mrst_nbseg", {1'b0, seg_nb}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            exp_d = 3'b001 << (k / 4);
            chk("mrst_scan", {5'b0, dig}, {5'b0, exp_d});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
